mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-outstanding memory port between an instruction
//             fetch requester and a data (load/store) requester. Data wins by
//             default; a streak counter bounds how long a waiting fetch can be
//             starved. A pipeline flush cancels an in-flight fetch, whose
//             memory handshake is still drained before the port is reused.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        flush,
  // data port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // shared memory port
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [3:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam int              SW         = $clog2(MAX_STREAK) + 1;
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [SW-1:0]   STREAK_ONE = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    I_DRAIN = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          grant_fetch;
  logic          grant_data;

  // Arbitration in IDLE: data first while the streak allows it, then an
  // unflushed fetch, then data anyway so the port never idles with work queued.
  always_comb begin
    grant_fetch = i_req && !flush && !(d_req && (streak < STREAK_MAX));
    grant_data  = d_req && !grant_fetch;
  end

  // Main FSM: grants load the registered memory request, which is held until
  // the m_ack cycle and dropped on the following edge (forcing one IDLE cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_addr  <= 32'd0;
      m_we    <= 4'd0;
      m_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state   <= D_BUSY;
            m_req   <= 1'b1;
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_wdata <= d_wdata;
            // Only count grants that actually made a fetch wait.
            if (i_req) begin
              if (streak != STREAK_MAX) streak <= streak + STREAK_ONE;
            end else begin
              streak <= '0;
            end
          end else if (grant_fetch) begin
            state   <= I_BUSY;
            m_req   <= 1'b1;
            m_addr  <= i_addr;
            m_we    <= 4'd0;
            m_wdata <= 32'd0;
            streak  <= '0;
          end
        end
        I_BUSY: begin
          if (m_ack) begin
            state <= IDLE;
            m_req <= 1'b0;
          end else if (flush) begin
            // Memory still owes us an ack; wait for it silently.
            state <= I_DRAIN;
          end
        end
        D_BUSY, I_DRAIN: begin
          if (m_ack) begin
            state <= IDLE;
            m_req <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  // Completion pulses follow m_ack in the owning state; a flush on the ack
  // cycle kills the fetch response.
  always_comb begin
    i_ready = (state == I_BUSY) && m_ack && !flush;
    d_ready = (state == D_BUSY) && m_ack;
    i_rdata = m_rdata;
    d_rdata = m_rdata;
  end

endmodule
`default_nettype wire
